// File: rtl/alu_pipe.sv
// 32-bit integer ALU with one registered output stage.
// Sixteen ops (add/sub, compares, logic, shifts, LUI, move, multiply) with a 1-cycle latency.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic [WIDTH-1:0] alu_result
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH + 2;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_MOVE  = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1101;
  localparam logic [3:0] OP_MULH  = 4'b1110;
  localparam logic [3:0] OP_MULHU = 4'b1111;

  // One shared adder: sub inverts b and injects the carry-in; bit WIDTH is the carry-out.
  function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub);
    logic [WIDTH-1:0] b_eff;
    b_eff = b ^ {WIDTH{sub}};
    return {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  endfunction

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic [SHW-1:0]   amt,
                                                   input logic             arith);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    if (arith) return sv >>> amt;
    else       return v >> amt;
  endfunction

  logic [WIDTH:0]          w_sum;
  logic                    w_is_sub;
  logic                    w_carry;
  logic                    w_slt;
  logic                    w_sltu;
  logic [SHW-1:0]          w_shamt;
  logic [WIDTH-1:0]        w_srl_in;
  logic [WIDTH-1:0]        w_shr;
  logic [WIDTH-1:0]        w_shift;
  logic                    w_mul_sgn;
  logic signed [WIDTH:0]   w_mul_a;
  logic signed [WIDTH:0]   w_mul_b;
  logic signed [PW-1:0]    w_prod;
  logic [WIDTH-1:0]        w_next;
  logic                    w_unused;
  logic [WIDTH-1:0]        r_result_p1;

  // Everything but ADD uses the subtract form so the compares share the adder.
  assign w_is_sub = (alu_control != OP_ADD);
  assign w_sum    = add_sub(alu_src1, alu_src2, w_is_sub);
  assign w_carry  = w_sum[WIDTH];
  assign w_sltu   = ~w_carry;
  assign w_slt    = (alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1]) ? alu_src1[WIDTH-1]
                                                              : w_sum[WIDTH-1];

  // Left shifts reuse the right shifter on bit-reversed data.
  assign w_shamt  = alu_src1[SHW-1:0];
  assign w_srl_in = (alu_control == OP_SLL) ? bit_reverse(alu_src2) : alu_src2;
  assign w_shr    = shift_right(w_srl_in, w_shamt, alu_control == OP_SRA);
  assign w_shift  = (alu_control == OP_SLL) ? bit_reverse(w_shr) : w_shr;

  // A single (WIDTH+1)-bit signed multiplier covers signed and unsigned high halves.
  assign w_mul_sgn = (alu_control == OP_MULH);
  assign w_mul_a   = {w_mul_sgn & alu_src1[WIDTH-1], alu_src1};
  assign w_mul_b   = {w_mul_sgn & alu_src2[WIDTH-1], alu_src2};
  assign w_prod    = PW'(w_mul_a) * PW'(w_mul_b);
  assign w_unused  = ^w_prod[PW-1:2*WIDTH];

  always_comb begin
    w_next = '0;
    case (alu_control)
      OP_ADD,
      OP_SUB:   w_next = w_sum[WIDTH-1:0];
      OP_SLT:   w_next = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU:  w_next = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_AND:   w_next = alu_src1 & alu_src2;
      OP_NOR:   w_next = ~(alu_src1 | alu_src2);
      OP_OR:    w_next = alu_src1 | alu_src2;
      OP_XOR:   w_next = alu_src1 ^ alu_src2;
      OP_SLL,
      OP_SRL,
      OP_SRA:   w_next = w_shift;
      OP_LUI:   w_next = {alu_src2[HALF-1:0], {HALF{1'b0}}};
      OP_MOVE:  w_next = alu_src2;
      OP_MUL:   w_next = w_prod[WIDTH-1:0];
      OP_MULH,
      OP_MULHU: w_next = w_prod[2*WIDTH-1:WIDTH];
      default:  w_next = '0;
    endcase
  end

  // Stage p1: output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_result_p1 <= '0;
    else         r_result_p1 <= w_next;
  end

  assign alu_result = r_result_p1;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized check of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  int n_vec  = 0;
  int n_fail = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint                  sa, sb, ps;
    logic [63:0]             pu;
    logic signed [31:0]      bs;
    int                      amt;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = sa * sb;
    pu  = {32'd0, a} * {32'd0, b};
    bs  = b;
    amt = int'(a % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a & b;
      4'd5:    return ~(a | b);
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return b << amt;
      4'd9:    return b >> amt;
      4'd10:   return bs >>> amt;
      4'd11:   return (b % 65536) * 65536;
      4'd12:   return b;
      4'd13:   return pu[31:0];
      4'd14:   return ps[63:32];
      default: return pu[63:32];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    n_vec++;
    assert (alu_result === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, alu_result, exp);
    end
  endtask

  // Drive one operation, wait exactly one edge, compare against the given value.
  task automatic apply(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    alu_control = op;
    alu_src1    = a;
    alu_src2    = b;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    resetn      = 1'b0;
    alu_control = 4'($urandom);
    alu_src1    = $urandom;
    alu_src2    = $urandom;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'h0);
      alu_control = 4'($urandom);
      alu_src1    = $urandom;
      alu_src2    = $urandom;
    end
    #2 resetn = 1'b1;

    a = 32'h01001011;
    b = 32'h10011111;
    apply("mul",   4'b1101, a, b, 32'h32233221);
    apply("mulh",  4'b1110, a, b, 32'h00100212);
    apply("mulhu", 4'b1111, a, b, 32'h00100212);
    apply("add",   4'b0000, a, b, 32'h11012122);
    apply("sub",   4'b0001, a, b, 32'hF0FEFF00);
    apply("slt",   4'b0010, a, b, 32'h00000001);
    apply("sltu",  4'b0011, a, b, 32'h00000001);
    apply("and",   4'b0100, a, b, 32'h00001011);
    apply("nor",   4'b0101, a, b, 32'hEEFEEEEE);
    apply("or",    4'b0110, a, b, 32'h11011111);
    apply("xor",   4'b0111, a, b, 32'h11010100);

    apply("sll4",  4'b1000, 32'hFFFFFF04, 32'h80000000, 32'h00000000);
    apply("srl4",  4'b1001, 32'hFFFFFF04, 32'h80000000, 32'h08000000);
    apply("sra4",  4'b1010, 32'hFFFFFF04, 32'h80000000, 32'hF8000000);
    apply("lui",   4'b1011, 32'h12345678, 32'h0000ABCD, 32'hABCD0000);
    apply("move",  4'b1100, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D);
    apply("mulh_neg",  4'b1110, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    apply("mulhu_neg", 4'b1111, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
    apply("slt_neg",   4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001);
    apply("sltu_neg",  4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);

    apply("add_wrap",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000);
    apply("mulh_min",  4'b1110, 32'h80000000, 32'h80000000, 32'h40000000);
    apply("sll0",  4'b1000, 32'hFFFFFFE0, 32'h9ABCDEF0, 32'h9ABCDEF0);
    apply("srl0",  4'b1001, 32'hFFFFFFE0, 32'h9ABCDEF0, 32'h9ABCDEF0);
    apply("sra0",  4'b1010, 32'hFFFFFFE0, 32'h9ABCDEF0, 32'h9ABCDEF0);
    apply("sra31", 4'b1010, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF);
    apply("sll31", 4'b1000, 32'h0000003F, 32'h00000003, 32'h80000000);
    apply("sub_wrap", 4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF);

    // Asynchronous reset between edges with a nonzero result held.
    apply("pre_rst", 4'b1100, 32'h0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    #2 resetn = 1'b0;
    #1 check("async_rst", 32'h0);
    alu_control = 4'b0000;
    alu_src1    = 32'h00000010;
    alu_src2    = 32'h00000020;
    @(posedge clk);
    #1 check("rst_held", 32'h0);
    #2 resetn = 1'b1;
    #1 check("rst_release", 32'h0);
    @(posedge clk);
    #1 check("first_after_rst", 32'h00000030);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) a = $urandom_range(0, 40);
      if (i % 7 == 0) b = {b[31], 31'($urandom_range(0, 3))};
      apply($sformatf("rand_op%0d", op), op, a, b, model(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
